// File: rtl/uart_crc_pkg.sv
// Shared definitions for the CRC-16 UART link (transmitter and receiver).
//   CRC16_POLY / CRC16_INIT : CRC-16/CCITT-FALSE parameters (no reflection, no final XOR)
//   FRAME_BITS / DATA_BITS / CRC_BITS : frame layout (start + data + crc + stop)
//   tx_state_e : transmitter state encoding
package uart_crc_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int FRAME_BITS = 26;
    localparam int DATA_BITS  = 8;
    localparam int CRC_BITS   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CRC     = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_CRCBITS = 3'd4,
        ST_STOP    = 3'd5
    } tx_state_e;

endpackage

// File: rtl/crc16_ccitt_step.sv
// One-bit CRC-16/CCITT update (polynomial 0x1021, MSB-first feed).
// Ports:
//   crc_in   in  16  current CRC register
//   data_bit in  1   next message bit
//   crc_next out 16  CRC after absorbing data_bit
module crc16_ccitt_step (
    input  logic [15:0] crc_in,
    input  logic        data_bit,
    output logic [15:0] crc_next
);
    import uart_crc_pkg::*;

    logic feedback;

    assign feedback = crc_in[15] ^ data_bit;
    assign crc_next = {crc_in[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/uart_crc_transmitter.sv
// UART transmitter sending one 26-bit frame per request:
//   start(0), data[0..7], crc[0..15], stop(1).
// The CRC-16/CCITT-FALSE of the payload is computed one bit per clock
// (8 cycles) before the start bit goes out.
// Ports:
//   clk      in  1   system clock, rising edge
//   reset    in  1   synchronous, active-high
//   tx_start in  1   request, only looked at while idle
//   data_in  in  8   payload, captured on acceptance
//   tx_out   out 1   serial line, idles high, registered
//   tx_busy  out 1   frame in progress
//   tx_done  out 1   one-cycle pulse as the stop bit completes
//   crc_out  out 16  CRC of the current/last frame
module uart_crc_transmitter #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [7:0]  data_in,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [15:0] crc_out
);
    import uart_crc_pkg::*;

    localparam int BAUD_COUNTER_MAX = CLK_FREQ / BAUD_RATE - 1;
    localparam int BAUD_CNT_W = (BAUD_COUNTER_MAX > 0) ? $clog2(BAUD_COUNTER_MAX + 1) : 1;
    localparam logic [BAUD_CNT_W-1:0] BAUD_MAX = BAUD_CNT_W'(BAUD_COUNTER_MAX);
    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_CRC_IDX  = 4'(CRC_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [BAUD_CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             data_q, data_d;
    logic [15:0]            crc_q, crc_d;
    logic                   tx_out_q, tx_out_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;

    logic                   baud_wrap;
    logic [2:0]             crc_bit_sel;
    logic [15:0]            crc_step_next;

    assign baud_wrap = (baud_cnt_q == BAUD_MAX);
    // The CRC is fed MSB first even though the line sends data LSB first.
    assign crc_bit_sel = 3'd7 - bit_idx_q[2:0];

    crc16_ccitt_step u_crc_step (
        .crc_in   (crc_q),
        .data_bit (data_q[crc_bit_sel]),
        .crc_next (crc_step_next)
    );

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        crc_d      = crc_q;
        tx_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    data_d     = data_in;
                    crc_d      = CRC16_INIT;
                    bit_idx_d  = 4'd0;
                    baud_cnt_d = '0;
                    state_d    = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_d = crc_step_next;
                if (bit_idx_q == LAST_DATA_IDX) begin
                    bit_idx_d  = 4'd0;
                    baud_cnt_d = '0;
                    state_d    = ST_START;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 4'd0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        bit_idx_d = 4'd0;
                        state_d   = ST_CRCBITS;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_CRCBITS: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == LAST_CRC_IDX) begin
                        bit_idx_d = 4'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    tx_done_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that the registered
        // line, busy and done flags change on the same edge as the state.
        tx_busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:   tx_out_d = 1'b0;
            ST_DATA:    tx_out_d = data_d[bit_idx_d[2:0]];
            ST_CRCBITS: tx_out_d = crc_d[bit_idx_d];
            default:    tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 4'd0;
            data_q     <= 8'd0;
            crc_q      <= 16'd0;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            crc_q      <= crc_d;
            tx_out_q   <= tx_out_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;
    assign crc_out = crc_q;

endmodule

// File: tb/tb_uart_crc_transmitter.sv
// Bench for uart_crc_transmitter with 16 clocks per bit.
module tb_uart_crc_transmitter;

    localparam int BAUD_RATE = 9600;
    localparam int CLK_FREQ  = 16 * 9600;
    localparam int BIT_CLKS  = 16;
    localparam int LATENCY   = 9 + 26 * BIT_CLKS;

    logic        clk;
    logic        reset;
    logic        tx_start;
    logic [7:0]  data_in;
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] crc_out;

    int tests_run;
    int tests_failed;
    int cyc;
    int done_cnt;
    int last_done_cyc;

    logic [7:0] exp_q[$];

    uart_crc_transmitter #(
        .BAUD_RATE (BAUD_RATE),
        .CLK_FREQ  (CLK_FREQ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .data_in  (data_in),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .crc_out  (crc_out)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial done_cnt = 0;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (run=%0d failed=%0d)", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Byte-wise CRC-16/CCITT-FALSE of a single payload byte.
    function automatic logic [15:0] model_crc(input logic [7:0] d);
        logic [15:0] c;
        c = 16'hFFFF ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = (c << 1) ^ 16'h1021;
            else       c = c << 1;
        end
        return c;
    endfunction

    // ---------------- scoreboard consumer ----------------
    // Watches the line for n_frames frames, popping one expected payload per
    // frame and checking CRC, every bit mid-period, and tx_done timing.
    task automatic monitor_frames(input int n_frames, input bit check_gap);
        logic        prev;
        logic        found;
        logic        early_done;
        logic [7:0]  d;
        logic [15:0] ec;
        logic [25:0] expv;
        logic [25:0] got;
        int          start_cyc;
        for (int f = 0; f < n_frames; f++) begin
            prev  = 1'b1;
            found = 1'b0;
            for (int w = 0; w < 64 && !found; w++) begin
                @(negedge clk);
                if (prev === 1'b1 && tx_out === 1'b0) found = 1'b1;
                else prev = tx_out;
            end
            tests_run++;
            if (!found) begin
                tests_failed++;
                $display("FAIL start_bit_timeout frame %0d: no start bit within 64 cycles, tx_out=%b", f, tx_out);
                return;
            end
            start_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_frame frame %0d: got a start bit, expected none", f);
                return;
            end
            d    = exp_q.pop_front();
            ec   = model_crc(d);
            expv = {1'b1, ec, d, 1'b0};

            tests_run++;
            if (crc_out !== ec) begin
                tests_failed++;
                $display("FAIL crc_out data=%h: got %h expected %h", d, crc_out, ec);
            end
            if (check_gap && f > 0) begin
                tests_run++;
                if (start_cyc - last_done_cyc != 9) begin
                    tests_failed++;
                    $display("FAIL frame_gap: got %0d high cycles expected 9", start_cyc - last_done_cyc);
                end
            end

            got        = '0;
            got[0]     = 1'b0;
            early_done = 1'b0;
            for (int off = 1; off <= 26 * BIT_CLKS; off++) begin
                @(negedge clk);
                if (off % BIT_CLKS == BIT_CLKS / 2) got[off / BIT_CLKS] = tx_out;
                if (off < 26 * BIT_CLKS && tx_done !== 1'b0) early_done = 1'b1;
            end
            got[0] = expv[0];
            last_done_cyc = cyc;

            tests_run++;
            if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_at_stop_end data=%h: got done=%b busy=%b expected done=1 busy=0", d, tx_done, tx_busy);
            end
            tests_run++;
            if (early_done) begin
                tests_failed++;
                $display("FAIL early_done data=%h: got tx_done high inside frame expected low", d);
            end
            tests_run++;
            if (got !== expv) begin
                tests_failed++;
                $display("FAIL frame_bits data=%h: got %b expected %b", d, got, expv);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || crc_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_values: got out=%b busy=%b done=%b crc=%h expected 1 0 0 0000", tx_out, tx_busy, tx_done, crc_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tests_run++;
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || crc_out !== 16'h0000) begin
                tests_failed++;
                $display("FAIL idle_after_reset cycle %0d: got out=%b busy=%b done=%b crc=%h expected 1 0 0 0000", i, tx_out, tx_busy, tx_done, crc_out);
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input logic [15:0] crc_ref);
        int t0;
        @(negedge clk);
        tx_start = 1'b1;
        data_in  = d;
        t0       = cyc;
        exp_q.push_back(d);
        @(negedge clk);
        tx_start = 1'b0;
        data_in  = 8'($urandom_range(0, 255));
        tests_run++;
        if (tx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_accept data=%h: got %b expected 1", d, tx_busy);
        end
        monitor_frames(1, 1'b0);
        tests_run++;
        if (crc_out !== crc_ref) begin
            tests_failed++;
            $display("FAIL crc_reference data=%h: got %h expected %h", d, crc_out, crc_ref);
        end
        tests_run++;
        if (last_done_cyc - t0 != LATENCY) begin
            tests_failed++;
            $display("FAIL accept_to_done data=%h: got %0d cycles expected %0d", d, last_done_cyc - t0, LATENCY);
        end
        @(negedge clk);
        tests_run++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_after_done data=%h: got done=%b busy=%b out=%b expected 0 0 1", d, tx_done, tx_busy, tx_out);
        end
    endtask

    task automatic test_ignore_busy();
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        tx_start = 1'b1;
        data_in  = 8'h41;
        exp_q.push_back(8'h41);
        @(negedge clk);
        tx_start = 1'b0;
        fork
            monitor_frames(1, 1'b0);
            begin
                repeat (100) @(negedge clk);
                tx_start = 1'b1;
                data_in  = 8'hFF;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        tests_run++;
        if (done_cnt - dc0 != 1) begin
            tests_failed++;
            $display("FAIL ignore_busy_done_count: got %0d expected 1", done_cnt - dc0);
        end
        tests_run++;
        if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_busy_no_queue: got busy=%b out=%b expected 0 1", tx_busy, tx_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'h55;
        vals[1] = 8'hAA;
        vals[2] = 8'h55;
        @(negedge clk);
        tx_start = 1'b1;
        data_in  = vals[0];
        exp_q.push_back(vals[0]);
        fork
            monitor_frames(3, 1'b1);
            begin
                for (int k = 1; k <= 3; k++) begin
                    for (int w = 0; w < 20 && tx_busy !== 1'b1; w++) @(negedge clk);
                    tests_run++;
                    if (tx_busy !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL b2b_accept frame %0d: got busy=%b expected 1", k, tx_busy);
                    end
                    if (k == 3) begin
                        tx_start = 1'b0;
                    end else begin
                        data_in = vals[k];
                        exp_q.push_back(vals[k]);
                        for (int w = 0; w < 600 && tx_busy !== 1'b0; w++) @(negedge clk);
                    end
                end
            end
        join
        repeat (20) @(negedge clk);
        tests_run++;
        if (tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_release: got busy=%b expected 0", tx_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int          dc0;
        logic [25:0] fr;
        fr  = {1'b1, model_crc(8'h41), 8'h41, 1'b0};
        dc0 = done_cnt;
        @(negedge clk);
        tx_start = 1'b1;
        data_in  = 8'h41;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (208) @(negedge clk);
        tests_run++;
        if (tx_out !== fr[12]) begin
            tests_failed++;
            $display("FAIL bit12_before_reset: got %b expected %b", tx_out, fr[12]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || crc_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_frame_reset: got out=%b busy=%b done=%b crc=%h expected 1 0 0 0000", tx_out, tx_busy, tx_done, crc_out);
        end
        repeat (300) @(negedge clk);
        tests_run++;
        if (done_cnt != dc0 || tx_out !== 1'b1 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abandoned_frame: got done_pulses=%0d out=%b busy=%b expected 0 1 0", done_cnt - dc0, tx_out, tx_busy);
        end
        test_frame(8'h41, 16'hB915);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        last_done_cyc = 0;
        reset         = 1'b1;
        tx_start      = 1'b0;
        data_in       = 8'h00;

        test_reset();
        test_frame(8'h41, 16'hB915);
        test_frame(8'h00, 16'hE1F0);
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d frames left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
